// File: rtl/bananachine_pkg.sv
// Shared constants for the bananachine button conditioning and memory-mapped I/O path.
package bananachine_pkg;

    typedef enum int unsigned {
        BTN_START = 0,
        BTN_LEFT  = 1,
        BTN_RIGHT = 2
    } button_e;

    localparam int unsigned NUM_BUTTONS         = 3;
    localparam int unsigned DEBOUNCE_10MS_50MHZ = 500000;

    // Address basic_mem decodes to return the sticky button status word.
    localparam logic [15:0] BUTTON_STATUS_ADDR  = 16'hFF00;

    function automatic int unsigned debounce_cnt_width(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One button channel: 2-FF synchronizer, debounce counter, press pulse and
// sticky press flag cleared by an acknowledge.
module debounce_bit
    import bananachine_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ
) (
    input  logic clk,
    input  logic reset,
    input  logic sample,
    input  logic ack,
    output logic level,
    output logic press_pulse,
    output logic sticky
);

    localparam int unsigned       CNT_W    = debounce_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             stable;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             rise;

    always_comb begin
        accept = (sync2 != stable) && (cnt == CNT_LAST);
        rise   = accept && sync2;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            stable      <= 1'b0;
            cnt         <= '0;
            press_pulse <= 1'b0;
            sticky      <= 1'b0;
        end else begin
            sync1 <= sample;
            sync2 <= sync1;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (accept) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            press_pulse <= rise;
            // A press landing on the same edge as an ack must not be lost.
            sticky      <= rise | (sticky & ~ack);
        end
    end

    assign level = stable;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the raw game pushbuttons into debounced levels, press pulses and
// a sticky status word for the CPU's memory-mapped read path.
module button_conditioner
    import bananachine_pkg::*;
#(
    parameter int unsigned NUM_BUTTONS     = bananachine_pkg::NUM_BUTTONS,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ,
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned WIDTH           = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] raw_buttons,
    input  logic [NUM_BUTTONS-1:0] ack,
    output logic [NUM_BUTTONS-1:0] level,
    output logic [NUM_BUTTONS-1:0] press_pulse,
    output logic [NUM_BUTTONS-1:0] sticky,
    output logic [WIDTH-1:0]       status
);

    logic [NUM_BUTTONS-1:0] normalized;

    always_comb begin
        normalized = ACTIVE_LOW ? ~raw_buttons : raw_buttons;
        status     = '0;
        status[NUM_BUTTONS-1:0] = sticky;
    end

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_button
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk        (clk),
            .reset      (reset),
            .sample     (normalized[i]),
            .ack        (ack[i]),
            .level      (level[i]),
            .press_pulse(press_pulse[i]),
            .sticky     (sticky[i])
        );
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Conditions the raw game pushbuttons (start, left, right) before they reach the memory-mapped I/O in basic_mem.
- Per button, it provides a 2-FF synchronizer, a debounce counter, a one-cycle press pulse and a sticky "pressed" flag.
- The sticky flag is cleared by an acknowledge from the memory read path, so the CPU observes every press exactly once regardless of its polling rate.
- It sits between the top-level button pins and basic_mem's left/right/start inputs.

Parameters:
- NUM_BUTTONS, 3, number of independent button channels (bit 0 start, bit 1 left, bit 2 right).
- DEBOUNCE_CYCLES, 500000, consecutive cycles a synchronized level must differ from the stable level before it is accepted (10 ms at 50 MHz). Must be ≥ 1.
- ACTIVE_LOW, 1, if 1 the raw inputs are inverted before synchronization (board KEYs are low when pressed).
- WIDTH, 16, width of the status word read by the CPU.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- raw_buttons  input  NUM_BUTTONS  unsynchronized pin levels.
- ack  input  NUM_BUTTONS  per-button clear of the sticky flag; a one-cycle pulse from the memory read of the status word.
- level  output  NUM_BUTTONS  debounced level, 1 = pressed.
- press_pulse  output  NUM_BUTTONS  1-cycle pulse on each debounced press.
- sticky  output  NUM_BUTTONS  latched press, held until acked.
- status  output  WIDTH  {zero fill, sticky}, the memory-mapped read value.

Behaviour:

Reset:
- Asynchronous and active-high; all state clears immediately.
- Sync FFs, stable level, counters, press_pulse and sticky all go to 0.
- The sync FFs reset to the post-normalization inactive value, so a held button after reset debounces as a fresh press.

Input path:
- Normalize: n = ACTIVE_LOW ? ~raw : raw.
- sync1 <= n; sync2 <= sync1.
- Only sync2 is used downstream. The design never samples raw or sync1 in logic.

Debounce (per bit), evaluated at each edge:
- If sync2 == stable: cnt <= 0.
- Else if cnt == DEBOUNCE_CYCLES-1: stable <= sync2 and cnt <= 0.
- Else: cnt <= cnt+1.
- A glitch shorter than DEBOUNCE_CYCLES consecutive differing cycles resets the counter and never changes stable.
- Counter width is clog2(DEBOUNCE_CYCLES), with a minimum of 1 bit. The counter never wraps; it saturates by reload.

Latency:
- A raw change sampled at edge k updates stable at edge k+DEBOUNCE_CYCLES+1, i.e. DEBOUNCE_CYCLES+2 edges counting edge k.
- level = stable (registered, no combinational path from raw).

press_pulse:
- Registered, asserted for exactly the one cycle in which stable first reads 1 after a 0→1 update.
- Release (1→0) produces no pulse.

sticky:
- Set on the same edge stable goes 0→1.
- Cleared on an edge where ack[i]=1 and no set occurs.
- Simultaneous set and ack: set wins, so the press is not lost.
- ack while sticky is already 0 has no effect.
- Holding the button does not re-set sticky after an ack; a new press requires a debounced release first.

status:
- Combinational zero-extension of sticky to WIDTH; bits above NUM_BUTTONS are 0.

Independence: channels are fully independent, and simultaneous presses on multiple buttons are all captured.

Decomposition:
- bananachine_pkg holds:
  - BTN_START=0, BTN_LEFT=1, BTN_RIGHT=2
  - NUM_BUTTONS=3
  - DEBOUNCE_10MS_50MHZ=500000
  - the status-word address constant used by basic_mem's decode.
- One sub-module, debounce_bit, contains sync1/sync2, the counter, the stable register, and the pulse and sticky logic for a single button with an ack input. It is instantiated NUM_BUTTONS times via a generate loop.
- The top level adds only the polarity normalization and the status packing.

Test Plan (DEBOUNCE_CYCLES=4, ACTIVE_LOW=0 unless noted):
- Reset, then raw=000 for 10 cycles -> level=000, press_pulse=000, sticky=000, status=0x0000.
- raw[1] 0→1 before edge 1, held -> level[1] rises at edge 6, press_pulse[1] high only in the cycle after edge 6, sticky[1]=1, status=0x0002.
- raw[0] glitch high for 3 cycles, then low -> level, press_pulse and sticky all stay 0; the counter returns to 0.
- sticky[2] set; ack[2]=1 for one cycle -> sticky[2]=0 next cycle. With the button still held, no re-set occurs until release (debounced) and a new press.
- Press and ack arrive on the same edge for bit 0 -> sticky[0]=1 after the edge (set wins).
- ACTIVE_LOW=1 with raw=111 -> level=000. Drive raw[2]=0 held, then assert reset at cycle 3 -> all outputs 0 immediately; after release the press is recognized at edge DEBOUNCE_CYCLES+2 counted from the first post-reset edge.
